// File: rtl/fft_pkg.sv
// Shared defaults, complex bin type, streamer state encoding and the bit-reverse helper.
package fft_pkg;

  localparam int FFT_DATA_WIDTH = 32;
  localparam int MAX_IDX_W      = 12;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cbin_t;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } stream_state_t;

  // Reverses the low 'width' bits of val; bits above width come back zero.
  function automatic logic [MAX_IDX_W-1:0] bit_rev(input logic [MAX_IDX_W-1:0] val,
                                                   input int width);
    logic [MAX_IDX_W-1:0] rev;
    rev = {<<{val}};
    return rev >> (MAX_IDX_W - width);
  endfunction

endpackage

// File: rtl/fft_bin_streamer_if.sv
// Core-side input stream plus power-spectrum-side output stream of the bin streamer.
interface fft_bin_streamer_if
  import fft_pkg::*;
#(
  parameter int N_POINTS   = 512,
  parameter int DATA_WIDTH = FFT_DATA_WIDTH
);
  localparam int IDX_W = $clog2(N_POINTS);

  logic [DATA_WIDTH-1:0] core_data_in;
  logic                  core_valid_in;
  logic                  core_last_in;
  logic                  core_ready_out;
  logic [DATA_WIDTH-1:0] fft_data_out;
  logic                  fft_valid_out;
  logic                  fft_ready_in;
  logic                  fft_last_out;
  logic [IDX_W-1:0]      bin_index_out;
  logic                  frame_err_out;

  modport slave (
    input  core_data_in, core_valid_in, core_last_in, fft_ready_in,
    output core_ready_out, fft_data_out, fft_valid_out, fft_last_out,
    output bin_index_out, frame_err_out
  );

  modport master (
    output core_data_in, core_valid_in, core_last_in, fft_ready_in,
    input  core_ready_out, fft_data_out, fft_valid_out, fft_last_out,
    input  bin_index_out, frame_err_out
  );
endinterface

// File: rtl/fft_bin_ram.sv
// Frame buffer: one write port, one read port with a registered output (1-cycle latency).
// The read register only updates on i_rd_en, so it also holds a read while downstream stalls.
module fft_bin_ram #(
  parameter int DEPTH      = 512,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_W-1:0]     i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_dat,
  input  logic                  i_rd_en,
  input  logic [ADDR_W-1:0]     i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_dat
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_dat;
  end

  always_ff @(posedge i_clk) begin
    if (i_rd_en) o_rd_dat <= r_mem[i_rd_addr];
  end
endmodule

// File: rtl/fft_bin_streamer.sv
// Buffers one FFT frame, then streams bins 0..N/2 in natural order; first bin 2 cycles after last input,
// 1 bin/cycle, held stable under backpressure. FFT_BIT_REVERSE_EN: core delivers bit-reversed order.
module fft_bin_streamer
  import fft_pkg::*;
#(
  parameter int N_POINTS   = 512,
  parameter int DATA_WIDTH = FFT_DATA_WIDTH
) (
  input logic               clk_in,
  input logic               rst_in,
  fft_bin_streamer_if.slave bus
);
  localparam int IDX_W = $clog2(N_POINTS);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_WR  = CNT_W'(N_POINTS - 1);
  localparam logic [CNT_W-1:0] LAST_RD  = CNT_W'(N_POINTS / 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS / 2);

  stream_state_t         r_state;
  stream_state_t         w_state_nxt;
  logic                  r_core_rdy;
  logic                  r_frame_err;
  logic [CNT_W-1:0]      r_wr_cnt;
  logic [CNT_W-1:0]      r_rd_cnt;
  logic                  r_b_vld;
  logic [IDX_W-1:0]      r_b_idx;
  logic                  r_c_vld;
  logic                  r_c_last;
  logic [IDX_W-1:0]      r_c_idx;
  logic [DATA_WIDTH-1:0] r_c_dat;

  logic                  w_acc;
  logic                  w_err;
  logic                  w_c_take;
  logic                  w_b_take;
  logic                  w_issue;
  logic                  w_xfer;
  logic [IDX_W-1:0]      w_rd_addr;
  logic [DATA_WIDTH-1:0] w_ram_dat;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_state <= ST_FILL;
    else         r_state <= w_state_nxt;
  end

  // Stage B is the RAM read register, stage C the output register; ready ripples C -> B -> read issue.
  always_comb begin
    w_state_nxt = r_state;
    w_acc       = bus.core_valid_in && r_core_rdy;
    w_err       = w_acc && (bus.core_last_in != (r_wr_cnt == LAST_WR));
    w_c_take    = !r_c_vld || bus.fft_ready_in;
    w_b_take    = !r_b_vld || w_c_take;
    w_xfer      = r_c_vld && bus.fft_ready_in;
    w_issue     = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (w_acc && bus.core_last_in && (r_wr_cnt == LAST_WR)) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_issue = (r_rd_cnt <= LAST_RD) && w_b_take;
        if (w_xfer && r_c_last) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: w_state_nxt = ST_FILL;
      default:  w_state_nxt = ST_FILL;
    endcase
  end

`ifdef FFT_BIT_REVERSE_EN
  assign w_rd_addr = IDX_W'(bit_rev(MAX_IDX_W'(r_rd_cnt[IDX_W-1:0]), IDX_W));
`else
  assign w_rd_addr = r_rd_cnt[IDX_W-1:0];
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_core_rdy  <= 1'b0;
      r_frame_err <= 1'b0;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_b_vld     <= 1'b0;
      r_b_idx     <= '0;
      r_c_vld     <= 1'b0;
      r_c_last    <= 1'b0;
      r_c_idx     <= '0;
      r_c_dat     <= '0;
    end else begin
      r_core_rdy  <= (w_state_nxt == ST_FILL);
      r_frame_err <= w_err;

      if (r_state == ST_FLUSH || w_err) r_wr_cnt <= '0;
      else if (w_acc)                    r_wr_cnt <= r_wr_cnt + 1'b1;

      if (r_state == ST_FLUSH) r_rd_cnt <= '0;
      else if (w_issue)        r_rd_cnt <= r_rd_cnt + 1'b1;

      if (w_b_take) begin
        r_b_vld <= w_issue;
        if (w_issue) r_b_idx <= r_rd_cnt[IDX_W-1:0];
      end

      if (w_c_take) begin
        r_c_vld  <= r_b_vld;
        r_c_last <= r_b_vld && (r_b_idx == LAST_IDX);
        if (r_b_vld) begin
          r_c_idx <= r_b_idx;
          r_c_dat <= w_ram_dat;
        end
      end
    end
  end

  fft_bin_ram #(
    .DEPTH      (N_POINTS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .i_clk     (clk_in),
    .i_wr_en   (w_acc),
    .i_wr_addr (r_wr_cnt[IDX_W-1:0]),
    .i_wr_dat  (bus.core_data_in),
    .i_rd_en   (w_issue),
    .i_rd_addr (w_rd_addr),
    .o_rd_dat  (w_ram_dat)
  );

  assign bus.core_ready_out = r_core_rdy;
  assign bus.frame_err_out  = r_frame_err;
  assign bus.fft_valid_out  = r_c_vld;
  assign bus.fft_last_out   = r_c_last;
  assign bus.bin_index_out  = r_c_idx;
  assign bus.fft_data_out   = r_c_dat;
endmodule

// File: doc/fft_bin_streamer.md
FFT_BIN_STREAMER -- requirements
Module: fft_bin_streamer

Interface
REQ-001 SHALL have parameter N_POINTS, default 512, FFT frame length; power of two, 8..4096.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, complex bin width; {real[31:16], imag[15:0]}.
REQ-003 SHALL have port clk_in, input, 1, sole clock; all logic on posedge.
REQ-004 SHALL have port rst_in, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port core_data_in, input, DATA_WIDTH, raw FFT core output bin.
REQ-006 SHALL have port core_valid_in, input, 1, core bin valid.
REQ-007 SHALL have port core_last_in, input, 1, final bin of core frame.
REQ-008 SHALL have port core_ready_out, input-side ready, output, 1; high only in FILL.
REQ-009 SHALL have port fft_data_out, output, DATA_WIDTH, bin to power-spectrum stage.
REQ-010 SHALL have port fft_valid_out, output, 1, output bin valid.
REQ-011 SHALL have port fft_ready_in, input, 1, downstream ready.
REQ-012 SHALL have port fft_last_out, output, 1, high with bin N_POINTS/2.
REQ-013 SHALL have port bin_index_out, output, $clog2(N_POINTS), natural index of current output bin.
REQ-014 SHALL have port frame_err_out, output, 1, one-cycle pulse on frame-length error.

Function
REQ-015 SHALL be a 3-state FSM: FILL, DRAIN, FLUSH; FILL after reset.
REQ-016 FILL: input beat accepted when core_valid_in && core_ready_out; written to buffer at write count wr_cnt, wr_cnt increments.
REQ-017 FILL -> DRAIN on accepted beat with core_last_in high and wr_cnt == N_POINTS-1.
REQ-018 Accepted core_last_in with wr_cnt != N_POINTS-1, or beat at wr_cnt == N_POINTS-1 without last: pulse frame_err_out next cycle, discard frame, wr_cnt <= 0, stay FILL.
REQ-019 DRAIN: emit bins 0..N_POINTS/2 inclusive (N_POINTS/2+1 beats), ascending natural index; upper mirror bins never emitted.
REQ-020 Buffer read SHALL be synchronous, 1 cycle; first fft_valid_out SHALL assert exactly 2 cycles after the final input beat is accepted.
REQ-021 Output handshake: beat transfers when fft_valid_out && fft_ready_in; while valid && !ready, fft_data_out, bin_index_out, fft_last_out SHALL hold stable.
REQ-022 Throughput: one bin per cycle with fft_ready_in held high; no bubble between bins; a 1-entry skid register absorbs read-in-flight when ready drops.
REQ-023 DRAIN -> FLUSH after beat with fft_last_out transfers; FLUSH lasts 1 cycle, clears counters, -> FILL.
REQ-024 core_ready_out SHALL be 0 in DRAIN and FLUSH; core beats presented then are not accepted.
REQ-025 fft_valid_out SHALL never assert in FILL.
REQ-026 Counters SHALL use $clog2(N_POINTS)+1 bits; no wrap within a frame.

Reset
REQ-027 rst_in low SHALL immediately force: FSM FILL, counters 0, core_ready_out 0, fft_valid_out 0, fft_last_out 0, frame_err_out 0, bin_index_out 0, fft_data_out 0.
REQ-028 core_ready_out SHALL rise on first clk_in edge after rst_in deasserts.
REQ-029 Reset mid-DRAIN SHALL abandon the frame; no partial output after release.
REQ-030 Buffer contents SHALL NOT be reset.

Configuration
REQ-031 Macro FFT_BIT_REVERSE_EN defined: read address = bit-reverse of natural index (core delivers bit-reversed order); output natural order.
REQ-032 Macro FFT_BIT_REVERSE_EN undefined: read address = natural index (core delivers natural order); all timing identical.

Structure
REQ-033 Shared package fft_pkg SHALL hold: DATA_WIDTH default, complex bin typedef {real, imag} 16-bit signed each, streamer state enum.
REQ-034 Buffer SHALL be sub-module fft_bin_ram: single-port-write/single-port-read, 1-cycle registered read, inferable as BRAM.
REQ-035 Bit-reverse SHALL be a package function, not a separate module.

Verification (N_POINTS=8)
REQ-036 Core frame bins 0x0001_0000..0x0008_0000 in bit-reversed order, last on 8th, fft_ready_in=1 -> 5 beats, natural bins 0..4, last on index 4, first valid 2 cycles after last input.
REQ-037 Same frame, fft_ready_in toggling 1,0,0,1... -> same 5 values, each held stable while ready=0, none lost or duplicated.
REQ-038 core_last_in on 5th beat -> frame_err_out one-cycle pulse, no output; following correct frame streams normally.
REQ-039 rst_in low during 3rd output beat -> all outputs 0 immediately; after release core_ready_out=1, no residual bins.
REQ-040 Core beats presented during DRAIN -> core_ready_out=0, not written; next frame unaffected.
REQ-041 Build without FFT_BIT_REVERSE_EN, natural-order input 1..8 -> output 1..5.
